// File: rtl/mmr_bar0_router.sv
// BAR0 to MMR router: splits a 64-bit single-beat access into one or two
// 32-bit device cycles (low half, then high half) and assembles the reply.
//
// state | meaning
// IDLE  | waiting for a BAR0 request, req_ready high
// LO    | low 32-bit half on the MMR bus (offset bit 2 = 0)
// HI    | high 32-bit half on the MMR bus (offset bit 2 = 1)
// RESP  | response presented, waiting for rsp_ready
module mmr_bar0_router #(
    parameter int ADDR_W      = 16,
    parameter int BASE_W      = 6,
    parameter int DEV_ADDR_W  = 10,
    parameter int DEV_COUNT   = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wr_i,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic [63:0]             req_wdata_i,
    input  logic [7:0]              req_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [63:0]             rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic [DEV_COUNT-1:0]    mmr_sel_o,
    output logic                    mmr_wr_o,
    output logic [DEV_ADDR_W-1:0]   mmr_addr_o,
    output logic [3:0]              mmr_be_o,
    output logic [31:0]             mmr_wdata_o,
    input  logic [DEV_COUNT*32-1:0] mmr_rdata_i,
    input  logic [DEV_COUNT-1:0]    mmr_ack_i
);

    localparam int IDX_W = (DEV_COUNT > 1) ? $clog2(DEV_COUNT) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BASE_W:0]  DEV_LIMIT = (BASE_W + 1)'(DEV_COUNT);
    localparam logic [31:0]      ERR_WORD = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

    state_t state_q, state_d;

    logic                    req_wr_q;
    logic [ADDR_W-1:3]       req_addr_q;
    logic [63:0]             wdata_q;
    logic [7:0]              wstrb_q;
    logic [63:0]             rdata_q;
    logic                    err_q;
    logic                    sel_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [BASE_W-1:0]       dev_idx;
    logic [IDX_W-1:0]        dev_sel;
    logic                    mapped;
    logic                    in_half;
    logic                    ack_hit;
    logic                    expire;
    logic                    half_done;
    logic                    half_err;
    logic [31:0]             cap_word;
    logic                    unused_addr_lsb;

    // Byte offset bits below the 64-bit word only matter through the strobes.
    assign unused_addr_lsb = ^req_addr_i[2:0];

    assign dev_idx   = req_addr_q[DEV_ADDR_W +: BASE_W];
    assign dev_sel   = dev_idx[IDX_W-1:0];
    assign mapped    = {1'b0, dev_idx} < DEV_LIMIT;
    assign in_half   = (state_q == S_LO) || (state_q == S_HI);
    // Only the selected device's ack counts, and only while sel is up.
    assign ack_hit   = sel_q && mmr_ack_i[dev_sel];
    // Ack in the expiry cycle wins over the timeout.
    assign expire    = sel_q && (cnt_q == '0) && !ack_hit;
    assign half_done = in_half && (!mapped || ack_hit || expire);
    assign half_err  = !mapped || expire;
    assign cap_word  = half_err ? ERR_WORD : mmr_rdata_i[dev_sel*32 +: 32];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and MMR bus / handshake outputs.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        rsp_err_o   = 1'b0;
        mmr_sel_o   = '0;
        mmr_wr_o    = 1'b0;
        mmr_addr_o  = '0;
        mmr_be_o    = '0;
        mmr_wdata_o = '0;
        if (sel_q) mmr_sel_o = DEV_COUNT'(1) << dev_sel;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (|req_wstrb_i[3:0])      state_d = S_LO;
                    else if (|req_wstrb_i[7:4]) state_d = S_HI;
                    else                        state_d = S_RESP;
                end
            end
            S_LO: begin
                mmr_wr_o    = req_wr_q;
                mmr_addr_o  = {req_addr_q[DEV_ADDR_W-1:3], 3'b000};
                mmr_be_o    = wstrb_q[3:0];
                mmr_wdata_o = wdata_q[31:0];
                if (half_done) state_d = (|wstrb_q[7:4]) ? S_HI : S_RESP;
            end
            S_HI: begin
                mmr_wr_o    = req_wr_q;
                mmr_addr_o  = {req_addr_q[DEV_ADDR_W-1:3], 3'b100};
                mmr_be_o    = wstrb_q[7:4];
                mmr_wdata_o = wdata_q[63:32];
                if (half_done) state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = rdata_q;
                rsp_err_o   = err_q;
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, per-half select/timeout and response assembly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_wr_q   <= 1'b0;
            req_addr_q <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            sel_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (state_q == S_IDLE && req_valid_i) begin
            req_wr_q   <= req_wr_i;
            req_addr_q <= req_addr_i[ADDR_W-1:3];
            wdata_q    <= req_wdata_i;
            wstrb_q    <= req_wstrb_i;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            sel_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (half_done) begin
            sel_q <= 1'b0;
            cnt_q <= '0;
            if (half_err) err_q <= 1'b1;
            if (!req_wr_q) begin
                if (state_q == S_HI) rdata_q[63:32] <= cap_word;
                else                 rdata_q[31:0]  <= cap_word;
            end
        end else if (in_half) begin
            // First cycle of a mapped half only raises sel; the timer runs after.
            if (!sel_q) begin
                sel_q <= 1'b1;
                cnt_q <= CNT_LOAD;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule
